// File: rtl/led_matrix_rx.sv
// led_matrix_rx: receiving end of the LED-matrix serial link.
// Oversamples sclk/sdo/colEn on clk, deserialises MSB-first pixel words and
// emits one RAM-style write (pixOut/wrAdd/we) per received pixel.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rstn       asynchronous active-low reset (deassertion synchronised internally)
//   sclk       serial clock from transmitter (asynchronous, <= clk/4)
//   sdo        serial data, sampled on sclk rising edge
//   colEn      one-hot active column select
//   pixOut     received pixel word
//   wrAdd      pixel address {colIdx, rowIdx}
//   we         one-cycle write strobe qualifying pixOut/wrAdd
//   frameDone  one-cycle pulse with the write of the last row of the last column
//   err        one-cycle pulse on protocol error
//
// Optional feature macro LEDMATRIX_RX_STATS_EN adds:
//   pixCount   16-bit wrapping count of writes
//   errCount   8-bit saturating count of errors
//
// state  | meaning
// IDLE   | waiting for the first sclk rise of a column burst
// SHIFT  | collecting bits of the current word, idle timer running
// COMMIT | one cycle: present the completed word on the write port
module led_matrix_rx #(
  parameter int PIX_W        = 12,
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sclk,
  input  logic             sdo,
  input  logic [COLS-1:0]  colEn,
  output logic [PIX_W-1:0] pixOut,
  output logic [7:0]       wrAdd,
  output logic             we,
  output logic             frameDone,
  output logic             err
`ifdef LEDMATRIX_RX_STATS_EN
  ,
  output logic [15:0]      pixCount,
  output logic [7:0]       errCount
`endif
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(PIX_W + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t state, state_nxt;

  logic            rst_s1, rst_int_n;
  logic            sclk_s1, sclk_s2, sclk_d;
  logic            sdo_s1, sdo_s2, sdo_d;
  logic [COLS-1:0] col_s1, col_s2;

  logic [PIX_W-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [RW-1:0]    row_idx;
  logic [CW-1:0]    col_idx;
  logic [TW-1:0]    idle_cnt;

  logic            sclk_rise, col_onehot, col_match, last_bit, last_row;
  logic [CW-1:0]   col_enc;
  logic            we_nxt, fd_nxt, err_nxt;

  // Reset asserts asynchronously but releases in step with clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_s1    <= 1'b0;
      rst_int_n <= 1'b0;
    end else begin
      rst_s1    <= 1'b1;
      rst_int_n <= rst_s1;
    end
  end

  // sdo is taken from the same delayed stage as sclk_d so the data bit
  // used at a detected rise was sampled before that rise reached sclk_s2.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
      sdo_s1  <= 1'b0; sdo_s2  <= 1'b0; sdo_d  <= 1'b0;
      col_s1  <= '0;   col_s2  <= '0;
    end else begin
      sclk_s1 <= sclk;    sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
      sdo_s1  <= sdo;     sdo_s2  <= sdo_s1;  sdo_d  <= sdo_s2;
      col_s1  <= colEn;   col_s2  <= col_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;

  always_comb begin
    col_onehot = (col_s2 != '0) && ((col_s2 & (col_s2 - COLS'(1))) == '0);
    col_enc    = '0;
    for (int i = 0; i < COLS; i++)
      if (col_s2[i]) col_enc = CW'(i);
  end

  assign col_match = (col_s2 == (COLS'(1) << col_idx));
  assign last_bit  = (bit_cnt == BW'(PIX_W - 1));
  assign last_row  = (row_idx == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Column change beats a simultaneous sclk rise: the word is already void.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sclk_rise && col_onehot) state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (!col_match)                state_nxt = S_IDLE;
        else if (sclk_rise && last_bit) state_nxt = S_COMMIT;
        else if (!sclk_rise && idle_cnt == '0) state_nxt = S_IDLE;
      end
      S_COMMIT: state_nxt = last_row ? S_IDLE : S_SHIFT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // A timeout on a word boundary is just the end of a short burst, not an error.
  always_comb begin
    we_nxt  = (state == S_COMMIT);
    fd_nxt  = (state == S_COMMIT) && last_row && (col_idx == CW'(COLS - 1));
    err_nxt = ((state == S_IDLE) && sclk_rise && !col_onehot) ||
              ((state == S_SHIFT) && !col_match) ||
              ((state == S_SHIFT) && col_match && !sclk_rise &&
               (idle_cnt == '0) && (bit_cnt != '0));
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      we        <= 1'b0;
      frameDone <= 1'b0;
      err       <= 1'b0;
      pixOut    <= '0;
      wrAdd     <= '0;
    end else begin
      we        <= we_nxt;
      frameDone <= fd_nxt;
      err       <= err_nxt;
      if (we_nxt) begin
        pixOut <= shreg;
        wrAdd  <= 8'({col_idx, row_idx});
      end
    end
  end

  // idle_cnt is a down-counter reloaded on every accepted bit; zero = timed out.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      row_idx  <= '0;
      col_idx  <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          row_idx <= '0;
          if (sclk_rise && col_onehot) begin
            shreg    <= PIX_W'(sdo_d);
            bit_cnt  <= BW'(1);
            col_idx  <= col_enc;
            idle_cnt <= TW'(IDLE_TIMEOUT - 1);
          end
        end
        S_SHIFT: begin
          if (!col_match) begin
            row_idx <= '0;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            shreg    <= {shreg[PIX_W-2:0], sdo_d};
            bit_cnt  <= bit_cnt + BW'(1);
            idle_cnt <= TW'(IDLE_TIMEOUT - 1);
          end else if (idle_cnt == '0) begin
            row_idx <= '0;
            bit_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt - TW'(1);
          end
        end
        S_COMMIT: begin
          bit_cnt  <= '0;
          row_idx  <= last_row ? '0 : row_idx + RW'(1);
          idle_cnt <= TW'(IDLE_TIMEOUT - 1);
        end
        default: ;
      endcase
    end
  end

`ifdef LEDMATRIX_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pixCount <= '0;
      errCount <= '0;
    end else begin
      if (we) pixCount <= pixCount + 16'd1;
      if (err && errCount != 8'hFF) errCount <= errCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_led_matrix_rx.sv
module tb_led_matrix_rx;
  localparam int PIX_W = 12;
  localparam int ROWS  = 16;
  localparam int COLS  = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             sclk = 1'b0;
  logic             sdo = 1'b0;
  logic [COLS-1:0]  colEn = '0;
  logic [PIX_W-1:0] pixOut;
  logic [7:0]       wrAdd;
  logic             we, frameDone, err;
`ifdef LEDMATRIX_RX_STATS_EN
  logic [15:0]      pixCount;
  logic [7:0]       errCount;
`endif

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_exp = 0;
  int fd_seen = 0;
  int pix_model = 0;
  int err_model = 0;

  typedef struct packed {
    logic [7:0]       addr;
    logic [PIX_W-1:0] pix;
    logic             fd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  led_matrix_rx dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .sdo(sdo), .colEn(colEn),
    .pixOut(pixOut), .wrAdd(wrAdd), .we(we), .frameDone(frameDone), .err(err)
`ifdef LEDMATRIX_RX_STATS_EN
    , .pixCount(pixCount), .errCount(errCount)
`endif
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  // One serial bit at clk/8: data changes with sclk low, held across the rise.
  task automatic send_bit(logic b);
    sclk = 1'b0;
    sdo  = b;
    wait_clk(4);
    sclk = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_word(logic [PIX_W-1:0] w);
    for (int i = PIX_W - 1; i >= 0; i--) send_bit(w[i]);
    sclk = 1'b0;
  endtask

  // Reference model: word r of a burst on column c lands at c*ROWS+r.
  task automatic expect_write(int c, int r, logic [PIX_W-1:0] w);
    exp_t e;
    e.addr = 8'(c * ROWS + r);
    e.pix  = w;
    e.fd   = (c == COLS - 1) && (r == ROWS - 1);
    sb.push_back(e);
    pix_model++;
  endtask

  task automatic expect_err();
    err_exp++;
    err_model++;
  endtask

  // Monitor / scoreboard consumer, sampled away from the active edge.
  always @(negedge clk) begin
    if (we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h pix=%0h required no write", wrAdd, pixOut);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(wrAdd), 32'(mon_e.addr));
        check("pix_out", 32'(pixOut), 32'(mon_e.pix));
        check("frame_done", 32'(frameDone), 32'(mon_e.fd));
      end
    end else if (frameDone) begin
      checks++;
      errors++;
      $display("FAIL stray_frame_done actual=1 required=0");
    end
    if (err) err_seen++;
    if (frameDone) fd_seen++;
  end

  task automatic check_stats(string tag);
`ifdef LEDMATRIX_RX_STATS_EN
    check({tag, "_pix_count"}, 32'(pixCount), 32'(pix_model % 65536));
    check({tag, "_err_count"}, 32'(errCount), 32'((err_model > 255) ? 255 : err_model));
`else
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
`endif
  endtask

  initial begin
    logic             bad;
    logic [PIX_W-1:0] w;
    int               c, n, mode, nb;

    // Reset held with sclk toggling: every output must stay at zero.
    bad = 1'b0;
    colEn = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      sdo  = $urandom_range(0, 1);
      wait_clk(3);
      if (we || err || frameDone || pixOut != '0 || wrAdd != '0) bad = 1'b1;
    end
    check("reset_outputs_quiet", 32'(bad), 32'd0);
    sclk = 1'b0;
    wait_clk(2);
    rstn = 1'b1;
    wait_clk(6);

    // First rise after release starts a word.
    w = 12'(PIX_W'($urandom));
    expect_write(0, 0, w);
    send_word(w);
    wait_clk(80);
    check("post_reset_no_err", 32'(err_seen), 32'(err_exp));

    // Full frame: pixel {c, r, 3}, one frameDone at 0xFF.
    fd_seen = 0;
    for (int cc = 0; cc < COLS; cc++) begin
      colEn = COLS'(1) << cc;
      wait_clk(4);
      for (int r = 0; r < ROWS; r++) begin
        w = {4'(cc), 4'(r), 4'h3};
        expect_write(cc, r, w);
        send_word(w);
      end
      wait_clk(8);
    end
    check("frame_done_count", 32'(fd_seen), 32'd1);
    check("frame_sb_drained", 32'(sb.size()), 32'd0);

    // Partial word then silence: one err, no write; next word is row 0.
    colEn = 16'h0001;
    wait_clk(4);
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
    sclk = 1'b0;
    expect_err();
    wait_clk(80);
    check("timeout_err", 32'(err_seen), 32'(err_exp));
    check_stats("frame_plus_timeout");
    w = 12'(PIX_W'($urandom));
    expect_write(0, 0, w);
    send_word(w);
    wait_clk(80);
    check("boundary_timeout_no_err", 32'(err_seen), 32'(err_exp));

    // Single burst on column 2.
    fd_seen = 0;
    colEn = 16'h0004;
    wait_clk(4);
    for (int r = 0; r < ROWS; r++) begin
      w = 12'hA5C + 12'(r);
      expect_write(2, r, w);
      send_word(w);
    end
    wait_clk(8);
    check("burst_no_frame_done", 32'(fd_seen), 32'd0);
    check("burst_sb_drained", 32'(sb.size()), 32'd0);

    // Two columns selected at the first rise.
    colEn = 16'h0003;
    wait_clk(4);
    send_bit(1'b1);
    sclk = 1'b0;
    expect_err();
    wait_clk(8);
    check("bad_select_err", 32'(err_seen), 32'(err_exp));
    colEn = 16'h8000;
    wait_clk(4);
    expect_write(15, 0, 12'hFFF);
    send_word(12'hFFF);
    wait_clk(80);
    check("after_bad_select_err", 32'(err_seen), 32'(err_exp));

    // Random bursts with random endings.
    for (int k = 0; k < 8; k++) begin
      c    = $urandom_range(0, COLS - 1);
      n    = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      colEn = COLS'(1) << c;
      wait_clk(4);
      for (int r = 0; r < n; r++) begin
        w = 12'(PIX_W'($urandom));
        expect_write(c, r, w);
        send_word(w);
      end
      if (mode == 1) begin
        nb = $urandom_range(1, PIX_W - 1);
        for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
        sclk = 1'b0;
        expect_err();
      end else if (mode == 2) begin
        colEn = COLS'(1) << ((c + 1) % COLS);
        expect_err();
        wait_clk(20);
      end
      wait_clk(80);
      check("rand_err", 32'(err_seen), 32'(err_exp));
    end
    check("rand_sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a word: nothing is written, counters clear.
    colEn = 16'h0002;
    wait_clk(4);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rstn = 1'b0;
    pix_model = 0;
    err_model = 0;
    wait_clk(5);
    check_stats("mid_reset");
    sclk = 1'b0;
    rstn = 1'b1;
    wait_clk(80);
    check("mid_reset_no_write", 32'(sb.size()), 32'd0);
    check("mid_reset_no_err", 32'(err_seen), 32'(err_exp));
    w = 12'(PIX_W'($urandom));
    expect_write(1, 0, w);
    send_word(w);
    wait_clk(80);
    check_stats("final");

    wait_clk(20);
    check("final_sb_drained", 32'(sb.size()), 32'd0);
    check("final_err_total", 32'(err_seen), 32'(err_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_matrix_rx.md
Name: led_matrix_rx

Overview:
- Receiving end of the LED-matrix serial link. Models the panel side for simulation and for loop-back checking on hardware.
- Oversamples sclk/sdo/colEn on the system clock and deserialises MSB-first 12-bit pixel words.
- Emits one write per pixel on a RAM-style port (pixOut/wrAdd/we) that mirrors the transmitter's ramIn/wrAdd/we.
- A capture RAM or scoreboard can then be compared against the frame buffer the transmitter was loaded with.

Parameters:
- PIX_W, 12, bits per pixel word (4R/4G/4B).
- ROWS, 16, pixel words per column burst.
- COLS, 16, width of colEn, one-hot.
- IDLE_TIMEOUT, 64, clk cycles with no sclk rising edge before a partial burst is discarded.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- sclk  in  1  serial clock from transmitter; asynchronous to clk, max frequency clk/4.
- sdo  in  1  serial data; sampled on sclk rising edge.
- colEn  in  COLS  one-hot active column select.
- pixOut  out  PIX_W  received pixel word.
- wrAdd  out  8  pixel address {colIdx[3:0], rowIdx[3:0]}.
- we  out  1  one-cycle write strobe, qualifies pixOut/wrAdd.
- frameDone  out  1  one-cycle pulse after row ROWS-1 of column COLS-1 is written.
- err  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset (async assert, sync deassert internally): pixOut=0, wrAdd=0, we=0, frameDone=0, err=0, FSM=IDLE, all counters=0.
- Input sync: sclk, sdo and colEn each pass through a 2-flop synchroniser.
- sclk rise = sync_sclk & ~sclk_d. sdo is captured from the same synchronised stage as sclk_d.
- FSM states:
  - IDLE: on sclk rise with colEn one-hot, shift in the first bit, latch colIdx = encode(colEn), bitCnt=1, go to SHIFT. On sclk rise with colEn not one-hot: pulse err, stay in IDLE.
  - SHIFT: each sclk rise does shreg = {shreg[PIX_W-2:0], sdo} and bitCnt++. When bitCnt reaches PIX_W, go to COMMIT.
  - COMMIT, one cycle: we=1, pixOut=shreg, wrAdd={colIdx,rowIdx}, bitCnt=0. Then rowIdx++.
    - If rowIdx was ROWS-1, return to IDLE. Also pulse frameDone in the same cycle if colIdx==COLS-1.
    - Otherwise return to SHIFT.
- Latency: we asserts 4 clk cycles after the sclk pin edge that carries the last bit (2 sync + 1 edge detect + 1 COMMIT register).
- Timeout: in SHIFT, idleCnt counts clk cycles since the last sclk rise.
  - Reaching IDLE_TIMEOUT: discard the partial word, pulse err, reset rowIdx and bitCnt, go to IDLE.
  - At a word boundary (bitCnt==0) a timeout returns to IDLE without err.
- colEn change mid-burst: if synchronised colEn differs from the latched column in SHIFT, pulse err, discard the word, reset rowIdx, go to IDLE. colEn is sampled before the next sclk rise is processed.
- sclk rise during COMMIT cannot occur because sclk ≤ clk/4. The bench must not violate this; no recovery is required.
- rowIdx wraps ROWS-1→0. colIdx is never incremented; it is taken from colEn each burst.
- Mid-operation reset: all state is cleared immediately. No we is issued for the partial word.

Optional Feature:
LEDMATRIX_RX_STATS_EN
- Defined: adds outputs pixCount[15:0] and errCount[7:0].
  - pixCount increments on every we and wraps at 65535.
  - errCount increments on every err and saturates at 255.
  - Both reset to 0 by rstn.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rstn=0 with sclk toggling → we, pixOut, wrAdd, err, frameDone stay 0. First sclk rise after release enters SHIFT.
- Single burst: colEn=16'h0004, shift 16 words 12'hA5C…12'hA6B, sclk=clk/8 → 16 we pulses, wrAdd 8'h20..8'h2F, pixOut matches each word, no frameDone.
- Full frame: 16 columns colEn=1<<c, pixel value {c,r,4'h3} → 256 writes, exactly one frameDone on the write to wrAdd 8'hFF.
- Timeout: colEn=16'h0001, send 7 bits, idle 64 clks → err pulses once, no we. Next full word writes wrAdd 8'h00.
- Bad select: colEn=16'h0003 at first sclk rise → err, stays in IDLE, no we. Then colEn=16'h8000 and one word 12'hFFF → we, wrAdd 8'hF0, pixOut 12'hFFF.
- Stats (macro defined): run the full frame plus one timeout → pixCount=256, errCount=1. Apply rstn → both read 0.
